// File: rtl/clahe_pkg.sv
// Shared types and helpers for the CLAHE clip-and-redistribute block.
package clahe_pkg;

  localparam int NBINS_DEF  = 256;
  localparam int CNT_W_DEF  = 16;
  localparam int NTILES_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  localparam int BIN_AW = $clog2(NBINS_DEF);
  localparam int EXC_W  = CNT_W_DEF + BIN_AW;
  localparam int TILE_W = $clog2(NTILES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS1,
    ST_DRAIN1,
    ST_CALC,
    ST_PASS2,
    ST_DRAIN2,
    ST_DONE
  } clip_state_t;

  // Add two unsigned values and clamp the result at max_v (count widths up to 31 bits).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) return max_v;
    return s[31:0];
  endfunction

endpackage

// File: rtl/clahe_clip_redist_rd_pipe.sv
// Delay line that tags each histogram read with its bin address so the
// returning data can be paired with it RD_LAT cycles later.
module clahe_rd_pipe
  import clahe_pkg::*;
#(
  parameter int AW  = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [AW-1:0]  addr_q [LAT];
  logic [AW-1:0]  addr_d [LAT];

  // Shift the read tag one stage per cycle.
  always_comb begin
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  // Stage registers; reset empties the line so no stale return is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LAT; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/clahe_clip_redist.sv
// Per-tile CLAHE histogram clipper: pass 1 sums the excess above the clip
// threshold, pass 2 re-reads the bins, adds the evenly shared excess and
// streams out the inclusive CDF. Define CLAHE_CLIP_RESIDUAL_EN to hand the
// remainder of the excess division out one count per bin to the lowest bins.
module clahe_clip_redist
  import clahe_pkg::*;
#(
  parameter int NBINS  = NBINS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NTILES = NTILES_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  localparam int ADDR_W = $clog2(NBINS),
  localparam int ACC_W  = CNT_W + ADDR_W,
  localparam int TIDX_W = $clog2(NTILES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIDX_W-1:0] tile_idx,
  input  logic [CNT_W-1:0]  clip_th,
  output logic              busy,
  output logic              done,
  output logic              hist_rd_en,
  output logic [TIDX_W-1:0] hist_rd_tile,
  output logic [ADDR_W-1:0] hist_rd_addr,
  input  logic [CNT_W-1:0]  hist_rd_data,
  output logic              cdf_wr_en,
  output logic [TIDX_W-1:0] cdf_wr_tile,
  output logic [ADDR_W-1:0] cdf_wr_addr,
  output logic [CNT_W-1:0]  cdf_wr_data,
  output logic [ACC_W-1:0]  excess_total
);

  localparam logic [31:0] MAXV = 32'((64'd1 << CNT_W) - 64'd1);

  clip_state_t       state_q, state_d;
  logic [TIDX_W-1:0] tile_q, tile_d;
  logic [CNT_W-1:0]  th_q, th_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        drain_q, drain_d;
  logic [ACC_W-1:0]  excess_q, excess_d;
  logic [ACC_W-1:0]  excess_total_q, excess_total_d;
  logic [CNT_W-1:0]  share_q, share_d;
  logic [CNT_W-1:0]  cdf_q, cdf_d;
  logic              sat_q, sat_d;
`ifdef CLAHE_CLIP_RESIDUAL_EN
  logic [ADDR_W-1:0] residual_q, residual_d;
`endif

  logic              ret_valid;
  logic [ADDR_W-1:0] ret_addr;
  logic              pass1_ret, pass2_ret;
  logic [CNT_W-1:0]  over, clipped, cdf_next;
  logic [31:0]       v_sum;

  clahe_rd_pipe #(.AW(ADDR_W), .LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en_q),
    .in_addr   (rd_addr_q),
    .out_valid (ret_valid),
    .out_addr  (ret_addr)
  );

  // Clip the returning bin, build its redistributed value and the next CDF entry.
  always_comb begin
    pass1_ret = ret_valid && (state_q == ST_PASS1 || state_q == ST_DRAIN1);
    pass2_ret = ret_valid && (state_q == ST_PASS2 || state_q == ST_DRAIN2);
    over      = (hist_rd_data > th_q) ? hist_rd_data - th_q : '0;
    clipped   = (hist_rd_data > th_q) ? th_q : hist_rd_data;
    v_sum     = sat_add(32'(clipped), 32'(share_q), MAXV);
`ifdef CLAHE_CLIP_RESIDUAL_EN
    if (ret_addr < residual_q) v_sum = sat_add(v_sum, 32'd1, MAXV);
`endif
    cdf_next  = sat_q ? CNT_W'(MAXV) : CNT_W'(sat_add(32'(cdf_q), v_sum, MAXV));
  end

  // Next-state and registered-output logic for the two-pass sequence.
  always_comb begin
    state_d        = state_q;
    tile_d         = tile_q;
    th_d           = th_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    rd_en_d        = rd_en_q;
    rd_addr_d      = rd_addr_q;
    drain_d        = drain_q;
    excess_d       = excess_q;
    excess_total_d = excess_total_q;
    share_d        = share_q;
    cdf_d          = cdf_q;
    sat_d          = sat_q;
`ifdef CLAHE_CLIP_RESIDUAL_EN
    residual_d     = residual_q;
`endif
    if (pass1_ret) excess_d = excess_q + ACC_W'(over);
    if (pass2_ret) begin
      cdf_d = cdf_next;
      sat_d = (32'(cdf_next) == MAXV);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PASS1;
          tile_d    = tile_idx;
          th_d      = clip_th;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          excess_d  = '0;
          cdf_d     = '0;
          sat_d     = 1'b0;
        end
      end
      ST_PASS1, ST_PASS2: begin
        if (rd_addr_q == ADDR_W'(NBINS - 1)) begin
          state_d   = (state_q == ST_PASS1) ? ST_DRAIN1 : ST_DRAIN2;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          drain_d   = '0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN1: begin
        if (drain_q == 2'(RD_LAT - 1)) state_d = ST_CALC;
        else drain_d = drain_q + 1'b1;
      end
      ST_CALC: begin
        share_d        = CNT_W'(excess_q >> ADDR_W);
        excess_total_d = excess_q;
`ifdef CLAHE_CLIP_RESIDUAL_EN
        residual_d     = excess_q[ADDR_W-1:0];
`endif
        state_d        = ST_PASS2;
        rd_en_d        = 1'b1;
        rd_addr_d      = '0;
      end
      ST_DRAIN2: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any tile in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tile_q         <= '0;
      th_q           <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      drain_q        <= '0;
      excess_q       <= '0;
      excess_total_q <= '0;
      share_q        <= '0;
      cdf_q          <= '0;
      sat_q          <= 1'b0;
`ifdef CLAHE_CLIP_RESIDUAL_EN
      residual_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      tile_q         <= tile_d;
      th_q           <= th_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      drain_q        <= drain_d;
      excess_q       <= excess_d;
      excess_total_q <= excess_total_d;
      share_q        <= share_d;
      cdf_q          <= cdf_d;
      sat_q          <= sat_d;
`ifdef CLAHE_CLIP_RESIDUAL_EN
      residual_q     <= residual_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign hist_rd_en   = rd_en_q;
  assign hist_rd_addr = rd_addr_q;
  assign hist_rd_tile = tile_q;
  assign excess_total = excess_total_q;
  assign cdf_wr_en    = pass2_ret;
  assign cdf_wr_addr  = pass2_ret ? ret_addr : '0;
  assign cdf_wr_data  = pass2_ret ? cdf_next : '0;
  assign cdf_wr_tile  = tile_q;

endmodule

// File: tb/tb_clahe_clip_redist.sv
// Directed bench for clahe_clip_redist: a RD_LAT=1 instance covers the main
// scenarios and a RD_LAT=2 instance repeats the flat-histogram case.
module tb_clahe_clip_redist;

  localparam int NB = 256;
  localparam int CW = 16;
  localparam int TW = 5;
  localparam int AW = 8;
  localparam int EW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start1, start2;
  logic [TW-1:0] tile_idx;
  logic [CW-1:0] clip_th;

  logic          busy1, done1, rd_en1, wr_en1;
  logic [TW-1:0] rd_tile1, wr_tile1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [CW-1:0] rd_data1, wr_data1;
  logic [EW-1:0] excess1;

  logic          busy2, done2, rd_en2, wr_en2;
  logic [TW-1:0] rd_tile2, wr_tile2;
  logic [AW-1:0] rd_addr2, wr_addr2;
  logic [CW-1:0] rd_data2, rd_data2_a, wr_data2;
  logic [EW-1:0] excess2;

  logic [CW-1:0] hist_mem [NB];
  logic [CW-1:0] cap1 [NB];
  logic [CW-1:0] cap2 [NB];
  logic [TW-1:0] exp_tile;
  int            wr_count1 = 0, order_err1 = 0, tile_err1 = 0;
  int            wr_count2 = 0, order_err2 = 0, tile_err2 = 0;
  logic [AW-1:0] next_addr1 = '0, next_addr2 = '0;
  int            n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  clahe_clip_redist u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .tile_idx(tile_idx), .clip_th(clip_th),
    .busy(busy1), .done(done1), .hist_rd_en(rd_en1), .hist_rd_tile(rd_tile1),
    .hist_rd_addr(rd_addr1), .hist_rd_data(rd_data1), .cdf_wr_en(wr_en1),
    .cdf_wr_tile(wr_tile1), .cdf_wr_addr(wr_addr1), .cdf_wr_data(wr_data1),
    .excess_total(excess1)
  );

  clahe_clip_redist #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tile_idx(tile_idx), .clip_th(clip_th),
    .busy(busy2), .done(done2), .hist_rd_en(rd_en2), .hist_rd_tile(rd_tile2),
    .hist_rd_addr(rd_addr2), .hist_rd_data(rd_data2), .cdf_wr_en(wr_en2),
    .cdf_wr_tile(wr_tile2), .cdf_wr_addr(wr_addr2), .cdf_wr_data(wr_data2),
    .excess_total(excess2)
  );

  // Histogram RAM models with one and two cycles of read latency.
  always @(posedge clk) begin
    rd_data1   <= hist_mem[rd_addr1];
    rd_data2_a <= hist_mem[rd_addr2];
    rd_data2   <= rd_data2_a;
  end

  // Capture CDF writes mid-cycle and track address order and tile.
  always @(negedge clk) begin
    if (rst) next_addr1 = '0;
    else if (wr_en1) begin
      if (wr_addr1 != next_addr1) order_err1++;
      if (wr_tile1 != exp_tile) tile_err1++;
      cap1[wr_addr1] = wr_data1;
      next_addr1 = wr_addr1 + 1'b1;
      wr_count1++;
    end
    if (rst) next_addr2 = '0;
    else if (wr_en2) begin
      if (wr_addr2 != next_addr2) order_err2++;
      if (wr_tile2 != exp_tile) tile_err2++;
      cap2[wr_addr2] = wr_data2;
      next_addr2 = wr_addr2 + 1'b1;
      wr_count2++;
    end
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic setAll(input logic [CW-1:0] v);
    for (int i = 0; i < NB; i++) hist_mem[i] = v;
  endtask

  // Start one tile on the chosen instance (called #1 after an edge) and run
  // until done; returns the done cycle (start-sampling edge = cycle 0).
  task automatic applyStimulus(input bit sel, input logic [TW-1:0] tile,
                               input logic [CW-1:0] th, input bit mid_pulse,
                               output int done_cyc, output int busy_gap);
    int n;
    exp_tile = tile;
    tile_idx = tile;
    clip_th  = th;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    n = 1;
    busy_gap = 0;
    while (!(sel ? done2 : done1) && n < 3000) begin
      if (!(sel ? busy2 : busy1)) busy_gap++;
      if (mid_pulse && n == 300) begin
        start1   = 1'b1;
        tile_idx = 5'd9;
        clip_th  = '0;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start1 = 1'b0;
    done_cyc = n;
  endtask

  initial begin
    int dc, bg, base_wr, base_ord, base_tile, saw_done;
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    tile_idx = '0;
    clip_th = '0;
    exp_tile = '0;
    setAll('0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_done", done1, 0);
    checkOutput("rst_rd_en", rd_en1, 0);
    checkOutput("rst_rd_tile", rd_tile1, 0);
    checkOutput("rst_wr_en", wr_en1, 0);
    checkOutput("rst_excess", excess1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Flat histogram, threshold above every count.
    setAll(16'd10);
    base_wr = wr_count1; base_ord = order_err1; base_tile = tile_err1;
    applyStimulus(1'b0, 5'd3, 16'd100, 1'b0, dc, bg);
    checkOutput("flat_done_cyc", dc, 516);
    checkOutput("flat_busy_gap", bg, 0);
    @(posedge clk); #1;
    checkOutput("flat_done_pulse", done1, 0);
    checkOutput("flat_excess", excess1, 0);
    checkOutput("flat_wr_count", wr_count1 - base_wr, 256);
    checkOutput("flat_order", order_err1 - base_ord, 0);
    checkOutput("flat_tile", tile_err1 - base_tile, 0);
    checkOutput("flat_cdf0", cap1[0], 10);
    checkOutput("flat_cdf127", cap1[127], 1280);
    checkOutput("flat_cdf255", cap1[255], 2560);

    // Single tall bin: excess 900, share 3, residual 132.
    setAll('0);
    hist_mem[5] = 16'd1000;
    applyStimulus(1'b0, 5'd2, 16'd100, 1'b0, dc, bg);
    checkOutput("spike_excess", excess1, 900);
`ifdef CLAHE_CLIP_RESIDUAL_EN
    checkOutput("spike_cdf0", cap1[0], 4);
    checkOutput("spike_cdf5", cap1[5], 124);
    checkOutput("spike_cdf255", cap1[255], 1000);
`else
    checkOutput("spike_cdf0", cap1[0], 3);
    checkOutput("spike_cdf5", cap1[5], 118);
    checkOutput("spike_cdf255", cap1[255], 868);
`endif
    @(posedge clk); #1;

    // Zero threshold: everything becomes excess and is shared back.
    setAll(16'd4);
    applyStimulus(1'b0, 5'd7, 16'd0, 1'b0, dc, bg);
    checkOutput("th0_excess", excess1, 1024);
    checkOutput("th0_cdf0", cap1[0], 4);
    checkOutput("th0_cdf100", cap1[100], 404);
    checkOutput("th0_cdf255", cap1[255], 1024);
    @(posedge clk); #1;

    // Start pulsed mid-PASS2 is ignored; start right after done is taken.
    setAll(16'd10);
    base_wr = wr_count1; base_tile = tile_err1;
    applyStimulus(1'b0, 5'd1, 16'd100, 1'b1, dc, bg);
    checkOutput("mid_done_cyc", dc, 516);
    checkOutput("mid_busy_gap", bg, 0);
    checkOutput("mid_busy_at_done", busy1, 0);
    checkOutput("mid_tile", tile_err1 - base_tile, 0);
    checkOutput("mid_wr_count", wr_count1 - base_wr, 256);
    checkOutput("mid_cdf255", cap1[255], 2560);
    @(posedge clk); #1;
    checkOutput("idle_busy", busy1, 0);
    base_wr = wr_count1; base_tile = tile_err1;
    applyStimulus(1'b0, 5'd4, 16'd50, 1'b0, dc, bg);
    checkOutput("b2b_done_cyc", dc, 516);
    checkOutput("b2b_busy_gap", bg, 0);
    checkOutput("b2b_tile", tile_err1 - base_tile, 0);
    checkOutput("b2b_wr_count", wr_count1 - base_wr, 256);
    checkOutput("b2b_cdf255", cap1[255], 2560);
    @(posedge clk); #1;

    // Reset in the middle of PASS2 aborts the tile.
    tile_idx = 5'd6;
    clip_th  = 16'd100;
    exp_tile = 5'd6;
    start1   = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (399) @(posedge clk);
    #1;
    checkOutput("pre_rst_wr_en", wr_en1, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy1, 0);
    checkOutput("abort_wr_en", wr_en1, 0);
    checkOutput("abort_wr_data", wr_data1, 0);
    checkOutput("abort_wr_tile", wr_tile1, 0);
    checkOutput("abort_rd_en", rd_en1, 0);
    checkOutput("abort_excess", excess1, 0);
    base_wr = wr_count1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done1) saw_done++;
    end
    checkOutput("abort_no_done", saw_done, 0);
    checkOutput("abort_no_write", wr_count1 - base_wr, 0);
    base_wr = wr_count1; base_ord = order_err1;
    applyStimulus(1'b0, 5'd5, 16'd100, 1'b0, dc, bg);
    checkOutput("post_rst_done_cyc", dc, 516);
    checkOutput("post_rst_wr_count", wr_count1 - base_wr, 256);
    checkOutput("post_rst_order", order_err1 - base_ord, 0);
    checkOutput("post_rst_cdf255", cap1[255], 2560);
    @(posedge clk); #1;

    // Two-cycle read latency with the flat histogram.
    setAll(16'd10);
    base_wr = wr_count2; base_ord = order_err2; base_tile = tile_err2;
    applyStimulus(1'b1, 5'd3, 16'd100, 1'b0, dc, bg);
    checkOutput("lat2_done_cyc", dc, 518);
    checkOutput("lat2_busy_gap", bg, 0);
    checkOutput("lat2_excess", excess2, 0);
    @(posedge clk); #1;
    checkOutput("lat2_wr_count", wr_count2 - base_wr, 256);
    checkOutput("lat2_order", order_err2 - base_ord, 0);
    checkOutput("lat2_tile", tile_err2 - base_tile, 0);
    checkOutput("lat2_cdf0", cap2[0], 10);
    checkOutput("lat2_cdf127", cap2[127], 1280);
    checkOutput("lat2_cdf255", cap2[255], 2560);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
